// File: rtl/fcl_seq.sv
// Layer sequencer for the fcl_pro binary fully-connected PE: walks a descriptor table,
// issues activation/weight reads per output group and writes results ping-pong. Option: FCL_SEQ_PERF_EN.
module fcl_seq #(
  parameter  int PRO_WIDTH    = 8,
  parameter  int PRO_PARALLEL = 4,
  parameter  int ACC_WIDTH    = 32,
  parameter  int MAX_DIM      = 1024,
  parameter  int MAX_LAYERS   = 8,
  parameter  int WADDR_W      = 16,
  parameter  int PE_LAT       = 1,
  localparam int DW           = $clog2(MAX_DIM + 1),
  localparam int LW           = $clog2(MAX_LAYERS),
  localparam int SW           = $clog2(ACC_WIDTH),
  localparam int OW           = PRO_PARALLEL * PRO_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_we_i,
  input  logic [LW-1:0]           cfg_idx_i,
  input  logic [DW-1:0]           cfg_in_dim_i,
  input  logic [DW-1:0]           cfg_out_dim_i,
  input  logic [SW-1:0]           cfg_shift_i,
  input  logic                    start_i,
  input  logic [LW:0]             num_layers_i,
  input  logic                    stall_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [DW-1:0]           act_rd_addr_o,
  output logic                    act_rd_bank_o,
  output logic [WADDR_W-1:0]      w_rd_addr_o,
  output logic                    rd_en_o,
  output logic                    pe_clr_n_o,
  output logic                    pe_en_o,
  output logic [SW-1:0]           pe_shift_o,
  input  logic [OW-1:0]           pe_out_i,
  output logic                    act_wr_en_o,
  output logic [DW-1:0]           act_wr_addr_o,
  output logic [PRO_PARALLEL-1:0] act_wr_mask_o,
  output logic [OW-1:0]           act_wr_data_o
`ifdef FCL_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_busy_o,
  output logic [31:0]             perf_stall_o
`endif
);

  localparam int LAT_W = $clog2(PE_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_ACCUM, S_DRAIN, S_WRITE, S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [WADDR_W-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0]      icnt_q, icnt_d, grp_q, grp_d, groups_q, groups_d;
  logic [DW-1:0]      in_dim_q, in_dim_d, out_dim_q, out_dim_d;
  logic [LW:0]        layer_q, layer_d, nlay_q, nlay_d;
  logic [SW-1:0]      shift_q, shift_d;
  logic [LAT_W-1:0]   dcnt_q, dcnt_d;
  logic               bank_q, bank_d, err_q, err_d, pe_en_q;
  logic               wr_en;
  logic [DW-1:0]      d_in, d_out;

  // NOTE: the descriptor table is host-written configuration with no reset; it survives
  // a sequencer reset and is always written before a run uses it.
  logic [DW-1:0] tbl_in  [MAX_LAYERS];
  logic [DW-1:0] tbl_out [MAX_LAYERS];
  logic [SW-1:0] tbl_sh  [MAX_LAYERS];

  always_ff @(posedge clk_i) begin
    if (cfg_we_i && !busy_o) begin
      tbl_in[cfg_idx_i]  <= cfg_in_dim_i;
      tbl_out[cfg_idx_i] <= cfg_out_dim_i;
      tbl_sh[cfg_idx_i]  <= cfg_shift_i;
    end
  end

  assign d_in  = tbl_in[layer_q[LW-1:0]];
  assign d_out = tbl_out[layer_q[LW-1:0]];

  always_comb begin
    // NOTE: every next-state signal takes its current value first so no path infers a latch.
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    icnt_d    = icnt_q;
    grp_d     = grp_q;
    groups_d  = groups_q;
    in_dim_d  = in_dim_q;
    out_dim_d = out_dim_q;
    layer_d   = layer_q;
    nlay_d    = nlay_q;
    shift_d   = shift_q;
    dcnt_d    = dcnt_q;
    bank_d    = bank_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        err_d   = 1'b0;
        wcnt_d  = '0;
        bank_d  = 1'b0;
        layer_d = '0;
        nlay_d  = num_layers_i;
        if (num_layers_i == '0 || num_layers_i > (LW+1)'(MAX_LAYERS)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (d_in == '0 || d_out == '0 || d_in > DW'(MAX_DIM) || d_out > DW'(MAX_DIM)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          in_dim_d  = d_in;
          out_dim_d = d_out;
          groups_d  = DW'((int'(d_out) + PRO_PARALLEL - 1) / PRO_PARALLEL);
          shift_d   = tbl_sh[layer_q[LW-1:0]];
          grp_d     = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        icnt_d  = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: if (!stall_i) begin
        icnt_d = icnt_q + DW'(1);
        wcnt_d = wcnt_q + WADDR_W'(1);
        if (icnt_q == in_dim_q - DW'(1)) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == LAT_W'(PE_LAT - 1)) state_d = S_WRITE;
        else                              dcnt_d  = dcnt_q + LAT_W'(1);
      end
      S_WRITE: begin
        if (grp_q == groups_q - DW'(1)) begin
          bank_d = ~bank_q;
          if (layer_q + (LW+1)'(1) == nlay_q) begin
            state_d = S_FIN;
          end else begin
            layer_d = layer_q + (LW+1)'(1);
            state_d = S_LOAD;
          end
        end else begin
          grp_d   = grp_q + DW'(1);
          state_d = S_CLEAR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      icnt_q    <= '0;
      grp_q     <= '0;
      groups_q  <= '0;
      in_dim_q  <= '0;
      out_dim_q <= '0;
      layer_q   <= '0;
      nlay_q    <= '0;
      shift_q   <= '0;
      dcnt_q    <= '0;
      bank_q    <= 1'b0;
      err_q     <= 1'b0;
      pe_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      icnt_q    <= icnt_d;
      grp_q     <= grp_d;
      groups_q  <= groups_d;
      in_dim_q  <= in_dim_d;
      out_dim_q <= out_dim_d;
      layer_q   <= layer_d;
      nlay_q    <= nlay_d;
      shift_q   <= shift_d;
      dcnt_q    <= dcnt_d;
      bank_q    <= bank_d;
      err_q     <= err_d;
      pe_en_q   <= rd_en_o;
    end
  end

  // Outputs decode the current state so an async reset silences them in the same cycle.
  assign busy_o        = !(state_q inside {S_IDLE, S_FIN});
  assign done_o        = (state_q == S_FIN);
  assign err_o         = err_q;
  assign rd_en_o       = (state_q == S_ACCUM) && !stall_i;
  assign act_rd_addr_o = icnt_q;
  assign w_rd_addr_o   = wcnt_q;
  assign act_rd_bank_o = bank_q;
  assign pe_clr_n_o    = !(state_q inside {S_IDLE, S_CLEAR});
  assign pe_en_o       = pe_en_q;
  assign pe_shift_o    = shift_q;
  assign wr_en         = (state_q == S_WRITE);
  assign act_wr_en_o   = wr_en;
  assign act_wr_addr_o = wr_en ? DW'(int'(grp_q) * PRO_PARALLEL) : '0;
  assign act_wr_data_o = wr_en ? pe_out_i : '0;

  always_comb begin
    act_wr_mask_o = '0;
    for (int k = 0; k < PRO_PARALLEL; k++)
      act_wr_mask_o[k] = wr_en && ((int'(grp_q) * PRO_PARALLEL + k) < int'(out_dim_q));
  end

`ifdef FCL_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_o && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == S_ACCUM && stall_i && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fcl_seq.sv
// Self-checking bench for fcl_seq: directed and randomized runs compared against
// read/write streams derived from the descriptor table with plain arithmetic.
module tb_fcl_seq;
  localparam int DW = 11;
  localparam int LW = 3;
  localparam int SW = 5;
  localparam int PP = 4;
  localparam int OW = 32;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [LW-1:0] cfg_idx_i = '0;
  logic [DW-1:0] cfg_in_dim_i = '0, cfg_out_dim_i = '0;
  logic [SW-1:0] cfg_shift_i = '0;
  logic          start_i = 1'b0;
  logic [LW:0]   num_layers_i = '0;
  logic          stall_i = 1'b0;
  logic          busy_o, done_o, err_o, act_rd_bank_o, rd_en_o, pe_clr_n_o, pe_en_o, act_wr_en_o;
  logic [DW-1:0] act_rd_addr_o, act_wr_addr_o;
  logic [WW-1:0] w_rd_addr_o;
  logic [SW-1:0] pe_shift_o;
  logic [OW-1:0] pe_out_i = '0, act_wr_data_o;
  logic [PP-1:0] act_wr_mask_o;
`ifdef FCL_SEQ_PERF_EN
  logic [31:0]   perf_busy_o, perf_stall_o;
`endif

  fcl_seq dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_in_dim_i(cfg_in_dim_i), .cfg_out_dim_i(cfg_out_dim_i), .cfg_shift_i(cfg_shift_i),
    .start_i(start_i), .num_layers_i(num_layers_i), .stall_i(stall_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .act_rd_addr_o(act_rd_addr_o),
    .act_rd_bank_o(act_rd_bank_o), .w_rd_addr_o(w_rd_addr_o), .rd_en_o(rd_en_o),
    .pe_clr_n_o(pe_clr_n_o), .pe_en_o(pe_en_o), .pe_shift_o(pe_shift_o), .pe_out_i(pe_out_i),
    .act_wr_en_o(act_wr_en_o), .act_wr_addr_o(act_wr_addr_o), .act_wr_mask_o(act_wr_mask_o),
    .act_wr_data_o(act_wr_data_o)
`ifdef FCL_SEQ_PERF_EN
    , .perf_busy_o(perf_busy_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) pe_out_i <= $urandom;

  // Observed streams, recorded mid-cycle.
  logic [32:0] q_rd[$];
  logic [15:0] q_wr[$];
  logic [31:0] q_wd[$], q_wpe[$];
  int pe_cnt = 0, done_cnt = 0, clr_cnt = 0, busy_cyc = 0;

  always @(negedge clk) begin
    if (rd_en_o) q_rd.push_back({act_rd_bank_o, pe_shift_o, act_rd_addr_o, w_rd_addr_o});
    if (act_wr_en_o) begin
      q_wr.push_back({act_rd_bank_o, act_wr_addr_o, act_wr_mask_o});
      q_wd.push_back(act_wr_data_o);
      q_wpe.push_back(pe_out_i);
    end
    if (pe_en_o) pe_cnt++;
    if (done_o) done_cnt++;
    if (busy_o && !pe_clr_n_o) clr_cnt++;
    if (busy_o) busy_cyc++;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model of the descriptor table and the expected streams.
  int m_in[8], m_out[8], m_sh[8];
  logic [32:0] exp_rd[$];
  logic [15:0] exp_wr[$];
  int exp_clr;
  bit exp_err, exp_bank;

  task automatic build_expect(input int nl);
    int w, grp;
    logic [PP-1:0] mask;
    exp_rd.delete();
    exp_wr.delete();
    exp_err = 0; exp_clr = 0; exp_bank = 0; w = 0;
    if (nl < 1 || nl > 8) exp_err = 1;
    else for (int l = 0; l < nl; l++) begin
      if (m_in[l] < 1 || m_out[l] < 1 || m_in[l] > 1024 || m_out[l] > 1024) begin
        exp_err = 1;
        break;
      end
      grp = (m_out[l] + PP - 1) / PP;
      for (int g = 0; g < grp; g++) begin
        exp_clr++;
        for (int i = 0; i < m_in[l]; i++) begin
          exp_rd.push_back({1'(l % 2), 5'(m_sh[l]), 11'(i), 16'(w)});
          w++;
        end
        for (int k = 0; k < PP; k++) mask[k] = (g * PP + k < m_out[l]);
        exp_wr.push_back({1'(l % 2), 11'(g * PP), mask});
      end
      exp_bank = 1'((l + 1) % 2);
    end
  endtask

  task automatic cfg(input int idx, input int in_d, input int out_d, input int sh);
    @(posedge clk); #1;
    cfg_we_i = 1'b1; cfg_idx_i = LW'(idx);
    cfg_in_dim_i = DW'(in_d); cfg_out_dim_i = DW'(out_d); cfg_shift_i = SW'(sh);
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    m_in[idx] = in_d; m_out[idx] = out_d; m_sh[idx] = sh;
  endtask

  // mode: 0 no stall, 1 random stall, 2 stall 3 cycles after 3 reads,
  // 3 start+cfg pulse while busy. cw: write descriptor 0 in the start cycle.
  task automatic run(input int nl, input int mode, input bit cw, input int cw_in, input int cw_out);
    int rd_base, wr_base, pe_base, dn_base, clr_base, busy_base, n, left;
    bit got, trig;
    if (cw) begin m_in[0] = cw_in; m_out[0] = cw_out; m_sh[0] = 2; end
    build_expect(nl);
    rd_base = q_rd.size(); wr_base = q_wr.size(); pe_base = pe_cnt;
    dn_base = done_cnt; clr_base = clr_cnt; busy_base = busy_cyc;
    got = 0; trig = 0; left = 0;
    @(posedge clk); #1;
    start_i = 1'b1; num_layers_i = (LW+1)'(nl);
    if (cw) begin
      cfg_we_i = 1'b1; cfg_idx_i = '0;
      cfg_in_dim_i = DW'(cw_in); cfg_out_dim_i = DW'(cw_out); cfg_shift_i = SW'(2);
    end
    @(posedge clk); #1;
    start_i = 1'b0; cfg_we_i = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (done_cnt != dn_base) begin got = 1; break; end
      if (mode == 1) stall_i = ($urandom_range(0, 3) == 0);
      if (mode == 2) begin
        if (!trig && q_rd.size() - rd_base >= 3) begin trig = 1; left = 3; end
        stall_i = (left > 0);
        if (left > 0) left--;
      end
      if (mode == 3 && c == 10) begin
        start_i = 1'b1; num_layers_i = (LW+1)'(1);
        cfg_we_i = 1'b1; cfg_idx_i = LW'(1); cfg_in_dim_i = DW'(7);
      end
      if (mode == 3 && c == 11) begin start_i = 1'b0; cfg_we_i = 1'b0; end
    end
    stall_i = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    n = q_rd.size() - rd_base;
    check("rd_count", 64'(n), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < n; i++)
      check($sformatf("rd_item%0d", i), 64'(q_rd[rd_base + i]), 64'(exp_rd[i]));
    check("pe_en_count", 64'(pe_cnt - pe_base), 64'(exp_rd.size()));
    n = q_wr.size() - wr_base;
    check("wr_count", 64'(n), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < n; i++) begin
      check($sformatf("wr_item%0d", i), 64'(q_wr[wr_base + i]), 64'(exp_wr[i]));
      check("wr_data", 64'(q_wd[wr_base + i]), 64'(q_wpe[wr_base + i]));
    end
    check("done_once", 64'(done_cnt - dn_base), 64'd1);
    check("clr_cycles", 64'(clr_cnt - clr_base), 64'(exp_clr));
    check("err", 64'(err_o), 64'(exp_err));
    check("final_bank", 64'(act_rd_bank_o), 64'(exp_bank));
    check("idle_busy", 64'(busy_o), 64'd0);
`ifdef FCL_SEQ_PERF_EN
    check("perf_busy", 64'(perf_busy_o), 64'(busy_cyc - busy_base));
    if (mode != 1) check("perf_stall", 64'(perf_stall_o), (mode == 2) ? 64'd3 : 64'd0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, base;
    bit seen;
    for (int i = 0; i < 8; i++) begin m_in[i] = 0; m_out[i] = 0; m_sh[i] = 0; end
    #3;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_rd_en", 64'(rd_en_o), 64'd0);
    check("rst_pe_clr_n", 64'(pe_clr_n_o), 64'd0);
    check("rst_pe_en", 64'(pe_en_o), 64'd0);
    check("rst_wr_en", 64'(act_wr_en_o), 64'd0);
    check("rst_waddr", 64'(w_rd_addr_o), 64'd0);
    check("rst_bank", 64'(act_rd_bank_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Four-layer network, no stall.
    cfg(0, 784, 16, 3); cfg(1, 16, 16, 2); cfg(2, 16, 16, 2); cfg(3, 16, 10, 1);
    run(4, 0, 0, 0, 0);

    // Partial last group and clear pulses.
    cfg(0, 5, 6, 4);
    run(1, 0, 0, 0, 0);

    // Three-cycle stall inside the accumulate burst.
    cfg(0, 8, 4, 7);
    run(1, 2, 0, 0, 0);

    // Bad descriptor on layer 1, then recovery and other error causes.
    cfg(0, 6, 5, 1); cfg(1, 0, 16, 2);
    run(2, 0, 0, 0, 0);
    cfg(0, 5, 6, 4);
    run(1, 0, 0, 0, 0);
    cfg(1, 3, 1100, 0);
    run(2, 0, 0, 0, 0);
    run(0, 0, 0, 0, 0);
    run(9, 0, 0, 0, 0);

    // Descriptor written in the same cycle as the accepted start.
    run(1, 0, 1, 3, 9);

    // start and cfg_we while busy are ignored.
    cfg(0, 5, 6, 1); cfg(1, 6, 3, 2);
    run(2, 3, 0, 0, 0);

    // Async reset mid-accumulate, then rerun from weight word 0.
    cfg(0, 784, 16, 3);
    base = q_rd.size();
    @(posedge clk); #1;
    start_i = 1'b1; num_layers_i = (LW+1)'(1);
    @(posedge clk); #1;
    start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (q_rd.size() - base >= 20) begin seen = 1; break; end
    end
    check("reached_accum", 64'(seen), 64'd1);
    base = done_cnt;
    rst_ni = 1'b0;
    #1;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_pe_clr_n", 64'(pe_clr_n_o), 64'd0);
    check("abort_rd_en", 64'(rd_en_o), 64'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    cfg(0, 5, 6, 4);
    run(1, 0, 0, 0, 0);

    // Randomized tables with random stall.
    for (int it = 0; it < 6; it++) begin
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++)
        cfg(l, $urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(0, 31));
      run(nl, 1, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
